// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
// Two requesters share one 8x8 unsigned multiplier through an
// accept / multiply / respond handshake with round-robin or fixed priority.

module wallace_tree_unsigned (
   input  logic [7:0]  i_a,
   input  logic [7:0]  i_b,
   output logic [15:0] o_p
);

   logic [15:0] w_pp [8];
   logic [31:0] w_l1a, w_l1b, w_l2a, w_l2b, w_l3, w_l4;

   // 3:2 compressor over whole words; returns {carry, sum}. Carries out of
   // bit 15 are dropped, which is exact because the product fits in 16 bits.
   function automatic logic [31:0] csa(input logic [15:0] x,
                                       input logic [15:0] y,
                                       input logic [15:0] z);
      logic [15:0] s;
      logic [15:0] c;
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
      return {c, s};
   endfunction

   for (genvar gi = 0; gi < 8; gi++) begin : g_pp
      assign w_pp[gi] = i_b[gi] ? ({8'd0, i_a} << gi) : 16'd0;
   end

   // Eight partial products reduce 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
   assign w_l1a = csa(w_pp[0], w_pp[1], w_pp[2]);
   assign w_l1b = csa(w_pp[3], w_pp[4], w_pp[5]);
   assign w_l2a = csa(w_l1a[15:0], w_l1a[31:16], w_l1b[15:0]);
   assign w_l2b = csa(w_l1b[31:16], w_pp[6], w_pp[7]);
   assign w_l3  = csa(w_l2a[15:0], w_l2a[31:16], w_l2b[15:0]);
   assign w_l4  = csa(w_l3[15:0], w_l3[31:16], w_l2b[31:16]);
   assign o_p   = w_l4[15:0] + w_l4[31:16];

endmodule

module mult_share_arbiter #(
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   input  logic        rsp0_ready,
   input  logic        rsp1_ready,
   output logic [15:0] rsp_product,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_grant;
   logic        r_last_grant;
   logic [7:0]  r_op_a;
   logic [7:0]  r_op_b;
   logic [15:0] r_product;
   logic [15:0] w_mul;
   logic        w_sel;
   logic        w_accept;
   logic        w_rsp_ready;

   wallace_tree_unsigned u_mul (
      .i_a (r_op_a),
      .i_b (r_op_b),
      .o_p (w_mul)
   );

   // On a tie round-robin hands the grant to whoever did not win last time.
   always_comb begin
      if (PRIO_FIXED)
         w_sel = ~req0_valid;
      else if (req0_valid && req1_valid)
         w_sel = ~r_last_grant;
      else
         w_sel = req1_valid;
      w_accept    = (r_state == IDLE) && (req0_valid || req1_valid);
      w_rsp_ready = r_grant ? rsp1_ready : rsp0_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_op_a       <= 8'd0;
         r_op_b       <= 8'd0;
         r_product    <= 16'd0;
      end else begin
         if (w_accept) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_op_a       <= w_sel ? req1_a : req0_a;
            r_op_b       <= w_sel ? req1_b : req0_b;
         end
         if (r_state == MUL)
            r_product <= w_mul;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = MUL;
         MUL:     w_next = RESP;
         RESP:    if (w_rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Ready is gated by rst_n so nothing is offered while reset is held.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (rst_n && (r_state == IDLE)) begin
         req0_ready = req0_valid & ~w_sel;
         req1_ready = req1_valid & w_sel;
      end
      rsp0_valid = (r_state == RESP) & ~r_grant;
      rsp1_valid = (r_state == RESP) & r_grant;
      busy       = (r_state != IDLE);
   end

   assign rsp_product = r_product;

endmodule

// File: tb/tb_mult_share_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mult_share_arbiter: one round-robin and one
// fixed-priority instance driven by the same stimulus.

module tb_mult_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0Valid, req1Valid;
   logic [7:0]  req0A, req0B, req1A, req1B;
   logic        rsp0Ready, rsp1Ready;

   logic        req0Ready, req1Ready, rsp0Valid, rsp1Valid, busy;
   logic [15:0] product;
   logic        fReq0Ready, fReq1Ready, fRsp0Valid, fRsp1Valid, fBusy;
   logic [15:0] fProduct;

   int total = 0;
   int bad   = 0;

   logic [7:0]  s0A [4] = '{8'd1, 8'd10, 8'd200, 8'd255};
   logic [7:0]  s0B [4] = '{8'd2, 8'd20, 8'd3,   8'd1};
   logic [7:0]  s1A [4] = '{8'd7, 8'd100, 8'd0,  8'd128};
   logic [7:0]  s1B [4] = '{8'd9, 8'd100, 8'd77, 8'd2};
   int          expGrant [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   int          expProd  [8] = '{2, 63, 200, 10000, 600, 0, 255, 256};
   logic [7:0]  fxA [5] = '{8'd1, 8'd10, 8'd200, 8'd255, 8'd15};
   logic [7:0]  fxB [5] = '{8'd2, 8'd20, 8'd3,   8'd1,   8'd15};
   int          fxProd [5] = '{2, 200, 600, 255, 225};

   mult_share_arbiter #(.PRIO_FIXED(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0Valid), .req1_valid(req1Valid),
      .req0_a(req0A), .req0_b(req0B), .req1_a(req1A), .req1_b(req1B),
      .req0_ready(req0Ready), .req1_ready(req1Ready),
      .rsp0_valid(rsp0Valid), .rsp1_valid(rsp1Valid),
      .rsp0_ready(rsp0Ready), .rsp1_ready(rsp1Ready),
      .rsp_product(product), .busy(busy)
   );

   mult_share_arbiter #(.PRIO_FIXED(1'b1)) dutFixed (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0Valid), .req1_valid(req1Valid),
      .req0_a(req0A), .req0_b(req0B), .req1_a(req1A), .req1_b(req1B),
      .req0_ready(fReq0Ready), .req1_ready(fReq1Ready),
      .rsp0_valid(fRsp0Valid), .rsp1_valid(fRsp1Valid),
      .rsp0_ready(rsp0Ready), .rsp1_ready(rsp1Ready),
      .rsp_product(fProduct), .busy(fBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                                input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                                input logic r0, input logic r1);
      req0Valid = v0; req0A = a0; req0B = b0;
      req1Valid = v1; req1A = a1; req1B = b1;
      rsp0Ready = r0; rsp1Ready = r1;
   endtask

   // Leaves the bench just after a rising edge with rst_n released: cycle 0.
   task automatic applyReset();
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic runStream(input bit fixedMode, input int nTrans);
      int accepts, resps, lastAccept, idx0, idx1, starve;
      logic r0, r1, v0, v1;
      logic [15:0] prod;
      accepts = 0; resps = 0; lastAccept = 0; idx0 = 0; idx1 = 0; starve = 0;
      applyReset();
      if (fixedMode)
         applyStimulus(1, fxA[0], fxB[0], 1, 8'd5, 8'd5, 1, 1);
      else
         applyStimulus(1, s0A[0], s0B[0], 1, s1A[0], s1B[0], 1, 1);
      for (int cyc = 0; cyc < 80 && resps < nTrans; cyc++) begin
         @(negedge clk);
         r0   = fixedMode ? fReq0Ready : req0Ready;
         r1   = fixedMode ? fReq1Ready : req1Ready;
         v0   = fixedMode ? fRsp0Valid : rsp0Valid;
         v1   = fixedMode ? fRsp1Valid : rsp1Valid;
         prod = fixedMode ? fProduct : product;
         if (fixedMode && r1) starve++;
         if ((r0 || r1) && accepts < nTrans) begin
            checkOutput("oneReady", {31'd0, r0 & r1}, 0);
            checkOutput("grant", {31'd0, r1}, fixedMode ? 0 : expGrant[accepts]);
            if (accepts > 0) checkOutput("spacing", cyc - lastAccept, 3);
            lastAccept = cyc;
            accepts++;
         end
         if (v0 || v1) begin
            checkOutput("rspIdx", {31'd0, v1}, fixedMode ? 0 : expGrant[resps]);
            checkOutput("product", {16'd0, prod}, fixedMode ? fxProd[resps] : expProd[resps]);
            resps++;
         end
         nextCycle();
         if (r0) begin
            idx0++;
            if (fixedMode && idx0 < 5) begin req0A = fxA[idx0]; req0B = fxB[idx0]; end
            if (!fixedMode && idx0 < 4) begin req0A = s0A[idx0]; req0B = s0B[idx0]; end
         end
         if (r1 && !fixedMode && idx1 < 3) begin
            idx1++;
            req1A = s1A[idx1]; req1B = s1B[idx1];
         end
      end
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      checkOutput("streamDone", resps, nTrans);
      if (fixedMode) checkOutput("starve", starve, 0);
   endtask

   initial begin
      logic [5:0] p0r, p1r, p0v, p1v;

      // Reset state with a request pending: nothing may be offered.
      rst_n = 1'b0;
      applyStimulus(1, 8'd3, 8'd5, 1, 8'd4, 8'd4, 1, 1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstReq0Ready", {31'd0, req0Ready}, 0);
      checkOutput("rstReq1Ready", {31'd0, req1Ready}, 0);
      checkOutput("rstBusy", {31'd0, busy}, 0);
      checkOutput("rstRspValid", {30'd0, rsp0Valid, rsp1Valid}, 0);
      checkOutput("rstProduct", {16'd0, product}, 0);

      // Single transaction 3x5 with accept in the first cycle after reset.
      applyReset();
      applyStimulus(1, 8'd3, 8'd5, 0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("c0Req0Ready", {31'd0, req0Ready}, 1);
      checkOutput("c0Busy", {31'd0, busy}, 0);
      nextCycle();
      req0Valid = 1'b0;
      @(negedge clk);
      checkOutput("c1Busy", {31'd0, busy}, 1);
      checkOutput("c1Rsp0Valid", {31'd0, rsp0Valid}, 0);
      nextCycle();
      @(negedge clk);
      checkOutput("c2Rsp0Valid", {31'd0, rsp0Valid}, 1);
      checkOutput("c2Product", {16'd0, product}, 15);
      checkOutput("c2Busy", {31'd0, busy}, 1);
      nextCycle();
      @(negedge clk);
      checkOutput("c3Busy", {31'd0, busy}, 0);
      checkOutput("c3ProductHeld", {16'd0, product}, 15);

      // Tie after reset: req0 (255x255) first, req1 (16x16) three cycles later.
      applyReset();
      applyStimulus(1, 8'd255, 8'd255, 1, 8'd16, 8'd16, 1, 1);
      p0r = 6'b000001; p1r = 6'b001000; p0v = 6'b000100; p1v = 6'b100000;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput("tieReq0Ready", {31'd0, req0Ready}, {31'd0, p0r[c]});
         checkOutput("tieReq1Ready", {31'd0, req1Ready}, {31'd0, p1r[c]});
         checkOutput("tieRsp0Valid", {31'd0, rsp0Valid}, {31'd0, p0v[c]});
         checkOutput("tieRsp1Valid", {31'd0, rsp1Valid}, {31'd0, p1v[c]});
         if (c == 2) checkOutput("tieProd0", {16'd0, product}, 65025);
         if (c == 5) checkOutput("tieProd1", {16'd0, product}, 256);
         nextCycle();
         if (c == 0) req0Valid = 1'b0;
         if (c == 3) req1Valid = 1'b0;
      end

      runStream(1'b0, 8);
      runStream(1'b1, 5);

      // Response back-pressure on requester 1 while requester 0 waits.
      applyReset();
      applyStimulus(0, 0, 0, 1, 8'd12, 8'd11, 0, 0);
      @(negedge clk);
      checkOutput("bpReq1Ready", {31'd0, req1Ready}, 1);
      nextCycle();
      applyStimulus(1, 8'd2, 8'd2, 0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("bpMulReq0Ready", {31'd0, req0Ready}, 0);
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         @(negedge clk);
         checkOutput("bpRsp1Valid", {31'd0, rsp1Valid}, 1);
         checkOutput("bpProduct", {16'd0, product}, 132);
         checkOutput("bpReq0Ready", {31'd0, req0Ready}, 0);
         checkOutput("bpRsp0Valid", {31'd0, rsp0Valid}, 0);
      end
      nextCycle();
      rsp1Ready = 1'b1;
      @(negedge clk);
      checkOutput("bpHandshake", {31'd0, rsp1Valid}, 1);
      nextCycle();
      rsp1Ready = 1'b0;
      @(negedge clk);
      checkOutput("bpIdleBusy", {31'd0, busy}, 0);
      checkOutput("bpReq0Accept", {31'd0, req0Ready}, 1);
      checkOutput("bpProductKept", {16'd0, product}, 132);

      // Asynchronous reset while requester 0's 2x2 is in MUL.
      nextCycle();
      req0Valid = 1'b0;
      #2;
      checkOutput("arBusyBefore", {31'd0, busy}, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("arBusy", {31'd0, busy}, 0);
      checkOutput("arProduct", {16'd0, product}, 0);
      checkOutput("arRspValid", {30'd0, rsp0Valid, rsp1Valid}, 0);
      nextCycle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("arNoRsp", {30'd0, rsp0Valid, busy}, 0);
         nextCycle();
      end
      applyStimulus(1, 8'd6, 8'd7, 0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("arNewAccept", {31'd0, req0Ready}, 1);
      nextCycle();
      req0Valid = 1'b0;
      nextCycle();
      @(negedge clk);
      checkOutput("arNewRsp", {31'd0, rsp0Valid}, 1);
      checkOutput("arNewProduct", {16'd0, product}, 42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: PRIO_FIXED, default 0, 0 = round-robin arbitration, 1 = fixed priority with requester 0 highest.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: req0_valid, req1_valid  input  1 each  requester N has operands pending.
REQ-005 Port: req0_a, req0_b, req1_a, req1_b  input  8 each  unsigned operands for requester N.
REQ-006 Port: req0_ready, req1_ready  output  1 each  operands of requester N accepted this cycle.
REQ-007 Port: rsp0_valid, rsp1_valid  output  1 each  result for requester N is presented.
REQ-008 Port: rsp0_ready, rsp1_ready  input  1 each  requester N consumes the result.
REQ-009 Port: rsp_product  output  16  unsigned product, shared by both response channels.
REQ-010 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 The block SHALL instantiate exactly one wallace_tree_unsigned and feed it only from internal registers op_a and op_b.
REQ-012 FSM states SHALL be IDLE, MUL and RESP, with a registered grant index g.
REQ-013 In IDLE, if any reqN_valid is high, the block SHALL select g, assert reqg_ready combinationally in that cycle, load op_a/op_b from requester g at the edge and move to MUL.
REQ-014 In IDLE with no valid request, the FSM SHALL remain in IDLE and both reqN_ready SHALL be 0.
REQ-015 reqN_ready SHALL be high only in IDLE, for at most one N, and only when reqN_valid is high.
REQ-016 In MUL, the multiplier output SHALL be registered into rsp_product at the edge, and the FSM SHALL move to RESP unconditionally.
REQ-017 In RESP, rspg_valid SHALL be 1 and the other rsp valid SHALL be 0.
REQ-018 In RESP, on rspg_ready = 1 the FSM SHALL return to IDLE; otherwise it SHALL hold with rsp_product stable.
REQ-019 Latency: for an accept at edge T, rspg_valid SHALL be high in the cycle after edge T+1.
REQ-020 Minimum spacing between two accepts SHALL be 3 cycles; no new request is accepted in MUL or RESP.
REQ-021 rsp_product SHALL equal op_a*op_b exactly as a full 16-bit unsigned result; no truncation or saturation (255*255 = 65025).
REQ-022 rsp_product SHALL retain its last value after the response handshake until the next MUL edge.
REQ-023 Round-robin mode (PRIO_FIXED=0), single requester valid: that requester SHALL be granted.
REQ-024 Round-robin mode, both requesters valid: the requester other than last_grant SHALL be granted.
REQ-025 last_grant SHALL update to g when a request is accepted.
REQ-026 Fixed mode (PRIO_FIXED=1): requester 0 SHALL win whenever req0_valid is high; requester 1 may starve.
REQ-027 rspN_ready outside the matching RESP cycle SHALL be ignored.
REQ-028 reqN_valid changes in MUL or RESP SHALL be ignored.
REQ-029 Requesters hold valid and operands stable until ready; the block performs no check of this.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 While rst_n = 0, the block SHALL immediately set: state IDLE, all ready/valid outputs 0, rsp_product 0, op_a/op_b 0, busy 0, last_grant = 1 (requester 0 wins the first tie).
REQ-032 Reset asserted in MUL or RESP SHALL discard the transaction; no response is issued after rst_n deasserts.
REQ-033 The first accept after reset SHALL be possible in the first clock cycle with rst_n = 1.

Verification
REQ-034 req0 with a=3, b=5, rsp0_ready tied 1 -> req0_ready in cycle 0, rsp0_valid in cycle 2 with rsp_product=15, busy high cycles 1-2.
REQ-035 After reset, both valid (req0 255x255, req1 16x16), all rsp_ready 1 -> req0 served first (65025), then req1 (256), accepts 3 cycles apart.
REQ-036 Both requesters continuously valid, round-robin -> grants alternate 0,1,0,1 over 8 transactions with correct products.
REQ-037 PRIO_FIXED=1, both continuously valid -> only req0 granted across 5 transactions; req1_ready never high.
REQ-038 rsp1_ready held 0 for 5 cycles in RESP -> rsp1_valid and rsp_product stable; no accept occurs; FSM returns to IDLE the cycle after rsp1_ready rises.
REQ-039 rst_n pulsed low during MUL -> all outputs 0 asynchronously; no rsp valid afterwards; a new request is served normally.
